pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage ARM pipeline. Watches the ID-stage

---
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW detection, branch flush,
// multi-cycle data-memory wait FSM and saturating stall/bubble counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W      = 4,
  parameter int MEM_WAIT_CYCLES = 3,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fwd_en,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src2_valid,
  input  logic                  id_src1_valid,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_req,
  input  logic                  ex_branch_taken,
  input  logic                  cnt_clear,
  output logic                  freeze_pc,
  output logic                  freeze_if_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  freeze_back,
  output logic [CNT_W-1:0]      mem_stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int                WC_W    = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
  localparam logic [WC_W-1:0]   WC_LOAD = WC_W'((MEM_WAIT_CYCLES > 0) ? MEM_WAIT_CYCLES - 1 : 0);
  localparam logic              WAIT_EN = (MEM_WAIT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            ex_hit;
  logic            mem_hit;
  logic            hazard;
  logic            mem_stall;
  logic            bubble;

  // Source/destination matching and RAW hazard decision
  always_comb begin
    ex_hit  = (id_src1_valid & (id_src1 == ex_dest)) | (id_src2_valid & (id_src2 == ex_dest));
    mem_hit = (id_src1_valid & (id_src1 == mem_dest)) | (id_src2_valid & (id_src2 == mem_dest));
    if (fwd_en) begin
      hazard = ex_wb_en & ex_mem_read & ex_hit;
    end else begin
      hazard = (ex_wb_en & ex_hit) | (mem_wb_en & mem_hit);
    end
    mem_stall = ((state == RUN) & mem_req & WAIT_EN) | ((state == WAIT) & (wait_cnt != '0));
  end

  // Prioritised control outputs; a memory stall holds everything, deferring branch/hazard
  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    freeze_back  = 1'b0;
    bubble       = 1'b0;
    if (rst) begin
      bubble = 1'b0;
    end else if (mem_stall) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      freeze_back  = 1'b1;
    end else if (ex_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hazard) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      flush_id_ex  = 1'b1;
      bubble       = 1'b1;
    end else begin
      bubble = 1'b0;
    end
  end

  // Wait-state FSM; the WAIT cycle with wait_cnt==0 is the release cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && WAIT_EN) begin
            state    <= WAIT;
            wait_cnt <= WC_LOAD;
          end
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WC_W'(1);
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters, clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_stall_cnt <= '0;
      bubble_cnt    <= '0;
    end else if (cnt_clear) begin
      mem_stall_cnt <= '0;
      bubble_cnt    <= '0;
    end else begin
      if (mem_stall && (mem_stall_cnt != CNT_MAX)) begin
        mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
      end
      if (bubble && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: a reference model pushes expected outputs to a scoreboard
// each cycle; scenario tasks add targeted checks with fixed expected values.
module tb_pipeline_hazard_ctrl;

  localparam int W = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_en, id_src1_valid, id_src2_valid, ex_wb_en, ex_mem_read;
  logic       mem_wb_en, mem_req, ex_branch_taken, cnt_clear;
  logic [3:0] id_src1, id_src2, ex_dest, mem_dest;

  logic        freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back;
  logic [15:0] mem_stall_cnt, bubble_cnt;
  logic        freeze_pc4, freeze_if_id4, flush_if_id4, flush_id_ex4, freeze_back4;
  logic [3:0]  mem_stall_cnt4, bubble_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .MEM_WAIT_CYCLES(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_valid(id_src2_valid), .id_src1_valid(id_src1_valid), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .mem_req(mem_req), .ex_branch_taken(ex_branch_taken),
    .cnt_clear(cnt_clear), .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .freeze_back(freeze_back),
    .mem_stall_cnt(mem_stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .MEM_WAIT_CYCLES(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_valid(id_src2_valid), .id_src1_valid(id_src1_valid), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .mem_req(mem_req), .ex_branch_taken(ex_branch_taken),
    .cnt_clear(cnt_clear), .freeze_pc(freeze_pc4), .freeze_if_id(freeze_if_id4),
    .flush_if_id(flush_if_id4), .flush_id_ex(flush_id_ex4), .freeze_back(freeze_back4),
    .mem_stall_cnt(mem_stall_cnt4), .bubble_cnt(bubble_cnt4)
  );

  // Reference model state
  bit m_wait = 1'b0;
  int m_wc   = 0;
  int m_ms   = 0;
  int m_bc   = 0;
  int m_ms4  = 0;
  int m_bc4  = 0;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [15:0] ms;
    logic [15:0] bc;
    logic [3:0]  ms4;
    logic [3:0]  bc4;
  } exp_t;

  exp_t exp_q[$];

  function bit model_stall();
    return (!m_wait && mem_req && (W != 0)) || (m_wait && (m_wc != 0));
  endfunction

  function bit model_hazard();
    bit e_hit, m_hit;
    e_hit = (id_src1_valid && (id_src1 == ex_dest)) || (id_src2_valid && (id_src2 == ex_dest));
    m_hit = (id_src1_valid && (id_src1 == mem_dest)) || (id_src2_valid && (id_src2 == mem_dest));
    if (fwd_en) return ex_wb_en && ex_mem_read && e_hit;
    return (ex_wb_en && e_hit) || (mem_wb_en && m_hit);
  endfunction

  // {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back}
  function logic [4:0] model_ctrl();
    if (rst) return 5'b00000;
    if (model_stall()) return 5'b11001;
    if (ex_branch_taken) return 5'b00110;
    if (model_hazard()) return 5'b11010;
    return 5'b00000;
  endfunction

  task automatic model_reset();
    m_wait = 1'b0; m_wc = 0; m_ms = 0; m_bc = 0; m_ms4 = 0; m_bc4 = 0;
  endtask

  // Advance the reference model on each rising edge
  always @(posedge clk) begin
    bit st, bub;
    if (rst) begin
      model_reset();
    end else begin
      st  = model_stall();
      bub = !st && !ex_branch_taken && model_hazard();
      if (cnt_clear) begin
        m_ms = 0; m_bc = 0; m_ms4 = 0; m_bc4 = 0;
      end else begin
        if (st && m_ms < 65535) m_ms++;
        if (st && m_ms4 < 15) m_ms4++;
        if (bub && m_bc < 65535) m_bc++;
        if (bub && m_bc4 < 15) m_bc4++;
      end
      if (!m_wait) begin
        if (mem_req && W > 0) begin
          m_wait = 1'b1;
          m_wc   = W - 1;
        end
      end else if (m_wc != 0) begin
        m_wc--;
      end else begin
        m_wait = 1'b0;
      end
    end
  end

  // Scoreboard: push the model's expectation, pop it and compare against both DUTs
  always @(negedge clk) begin
    exp_t e, g;
    if (rst) model_reset();
    e.ctrl = model_ctrl();
    e.ms   = m_ms[15:0];
    e.bc   = m_bc[15:0];
    e.ms4  = m_ms4[3:0];
    e.bc4  = m_bc4[3:0];
    exp_q.push_back(e);
    g = exp_q.pop_front();
    checks++;
    if ({freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back} !== g.ctrl) begin
      errors++;
      $display("FAIL sb_ctrl t=%0t got %b want %b", $time,
               {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back}, g.ctrl);
    end
    checks++;
    if ({freeze_pc4, freeze_if_id4, flush_if_id4, flush_id_ex4, freeze_back4} !== g.ctrl) begin
      errors++;
      $display("FAIL sb_ctrl4 t=%0t got %b want %b", $time,
               {freeze_pc4, freeze_if_id4, flush_if_id4, flush_id_ex4, freeze_back4}, g.ctrl);
    end
    checks++;
    if ({mem_stall_cnt, bubble_cnt} !== {g.ms, g.bc}) begin
      errors++;
      $display("FAIL sb_cnt t=%0t got %0d/%0d want %0d/%0d", $time,
               mem_stall_cnt, bubble_cnt, g.ms, g.bc);
    end
    checks++;
    if ({mem_stall_cnt4, bubble_cnt4} !== {g.ms4, g.bc4}) begin
      errors++;
      $display("FAIL sb_cnt4 t=%0t got %0d/%0d want %0d/%0d", $time,
               mem_stall_cnt4, bubble_cnt4, g.ms4, g.bc4);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fwd_en = 1'b1; id_src1_valid = 1'b0; id_src2_valid = 1'b0; ex_wb_en = 1'b0;
    ex_mem_read = 1'b0; mem_wb_en = 1'b0; mem_req = 1'b0; ex_branch_taken = 1'b0;
    cnt_clear = 1'b0; id_src1 = 4'd0; id_src2 = 4'd0; ex_dest = 4'd0; mem_dest = 4'd0;
  endtask

  task automatic clear_counters();
    next_cycle();
    idle_inputs();
    cnt_clear = 1'b1;
    sample();
    next_cycle();
    cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    mem_req = 1'b1;
    ex_branch_taken = 1'b1;
    sample();
    checks++;
    if ({freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000",
               {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back});
    end
    checks++;
    if ({mem_stall_cnt, bubble_cnt, mem_stall_cnt4, bubble_cnt4} !== 40'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d %0d want 0 0", mem_stall_cnt, bubble_cnt);
    end
    next_cycle();
    rst = 1'b0;
    mem_req = 1'b0;
    ex_branch_taken = 1'b0;
    sample();
    checks++;
    if (freeze_back !== 1'b0 || mem_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_release got fb=%b cnt=%0d want fb=0 cnt=0", freeze_back, mem_stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    clear_counters();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      sample();
      checks++;
      if (freeze_back !== ((i < 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL mem_wait_c%0d got %b want %b", i, freeze_back, (i < 3) ? 1'b1 : 1'b0);
      end
    end
    checks++;
    if (mem_stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL mem_stall_cnt got %0d want 3", mem_stall_cnt);
    end
    next_cycle();
    mem_req = 1'b0;
    sample();
  endtask

  task automatic test_load_use();
    clear_counters();
    fwd_en = 1'b1; ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dest = 4'd5;
    id_src1 = 4'd5; id_src1_valid = 1'b1;
    sample();
    checks++;
    if ({freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back} !== 5'b11010) begin
      errors++;
      $display("FAIL load_use got %b want 11010",
               {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back});
    end
    next_cycle();
    ex_mem_read = 1'b0;
    sample();
    checks++;
    if (freeze_pc !== 1'b0 || flush_id_ex !== 1'b0) begin
      errors++;
      $display("FAIL alu_fwd got pc=%b fl=%b want 0 0", freeze_pc, flush_id_ex);
    end
    checks++;
    if (bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL bubble_cnt got %0d want 1", bubble_cnt);
    end
    next_cycle();
    idle_inputs();
    sample();
  endtask

  task automatic test_no_fwd();
    next_cycle();
    idle_inputs();
    fwd_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd2; id_src2 = 4'd2; id_src2_valid = 1'b1;
    sample();
    checks++;
    if (flush_id_ex !== 1'b1 || freeze_pc !== 1'b1) begin
      errors++;
      $display("FAIL nofwd_src2 got fl=%b pc=%b want 1 1", flush_id_ex, freeze_pc);
    end
    next_cycle();
    id_src2_valid = 1'b0;
    sample();
    checks++;
    if (flush_id_ex !== 1'b0) begin
      errors++;
      $display("FAIL nofwd_invalid got %b want 0", flush_id_ex);
    end
    next_cycle();
    id_src2_valid = 1'b1;
    fwd_en = 1'b1;
    sample();
    checks++;
    if (flush_id_ex !== 1'b0) begin
      errors++;
      $display("FAIL fwd_mem_hit got %b want 0", flush_id_ex);
    end
    next_cycle();
    fwd_en = 1'b0;
    ex_branch_taken = 1'b1;
    sample();
    checks++;
    if ({freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back} !== 5'b00110) begin
      errors++;
      $display("FAIL branch_over_hazard got %b want 00110",
               {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back});
    end
    next_cycle();
    idle_inputs();
    sample();
  endtask

  task automatic test_branch_in_wait();
    next_cycle();
    idle_inputs();
    mem_req = 1'b1;
    sample();
    next_cycle();
    mem_req = 1'b0;
    ex_branch_taken = 1'b1;
    for (int i = 1; i < 4; i++) begin
      if (i > 1) next_cycle();
      sample();
      checks++;
      if ({flush_if_id, flush_id_ex, freeze_back} !== ((i < 3) ? 3'b001 : 3'b110)) begin
        errors++;
        $display("FAIL branch_wait_c%0d got %b want %b", i,
                 {flush_if_id, flush_id_ex, freeze_back}, (i < 3) ? 3'b001 : 3'b110);
      end
    end
    next_cycle();
    ex_branch_taken = 1'b0;
    sample();
  endtask

  task automatic test_back_to_back();
    next_cycle();
    idle_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      sample();
      checks++;
      if (freeze_back !== ((i % 4 != 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL b2b_c%0d got %b want %b", i, freeze_back, (i % 4 != 3) ? 1'b1 : 1'b0);
      end
    end
    next_cycle();
    mem_req = 1'b0;
    sample();
  endtask

  task automatic test_reset_mid_wait();
    next_cycle();
    idle_inputs();
    mem_req = 1'b1;
    sample();
    next_cycle();
    mem_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid_ctrl got %b want 00000",
               {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back});
    end
    sample();
    next_cycle();
    rst = 1'b0;
    sample();
    checks++;
    if (freeze_back !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_abort got %b want 0", freeze_back);
    end
  endtask

  task automatic test_saturate();
    clear_counters();
    mem_req = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i > 0) next_cycle();
      sample();
    end
    next_cycle();
    cnt_clear = 1'b1;
    sample();
    checks++;
    if (freeze_back !== 1'b1 || mem_stall_cnt4 !== 4'd15 || mem_stall_cnt !== 16'd21) begin
      errors++;
      $display("FAIL saturate got fb=%b c4=%0d c16=%0d want 1 15 21",
               freeze_back, mem_stall_cnt4, mem_stall_cnt);
    end
    next_cycle();
    cnt_clear = 1'b0;
    sample();
    checks++;
    if (mem_stall_cnt4 !== 4'd0 || mem_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clear_on_stall got c4=%0d c16=%0d want 0 0", mem_stall_cnt4, mem_stall_cnt);
    end
    next_cycle();
    mem_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      sample();
    end
  endtask

  initial begin
    test_reset();
    test_mem_wait();
    test_load_use();
    test_no_fwd();
    test_branch_in_wait();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturate();
    next_cycle();
    sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
